// File: rtl/path_stim_pkg.sv
// Shared types and constants for the path-test launch stimulus generator.
package path_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_LFSR   = 2'd1,
        MODE_PULSE  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    // Feedback taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

endpackage

// File: rtl/path_stim_lfsr.sv
// 16-bit Fibonacci LFSR; exposes the bit that becomes lfsr[0] after one step.
module path_stim_lfsr
    import path_stim_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic step,
    output logic nxt_bit
);

    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    assign lfsr_nxt = {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    assign nxt_bit  = lfsr_nxt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (load) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= lfsr_nxt;
        end
    end

endmodule

// File: rtl/path_stim_gen.sv
// Launch-side serial stimulus generator: one programmable burst per start,
// then drain, done pulse, and a CRC-16-CCITT signature of the emitted bits.
module path_stim_gen
    import path_stim_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter int          DRAIN_CYC = 2,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] burst_len,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [15:0]      sig
);

    state_t           state, state_nxt;
    mode_t            mode_q;
    logic [CNT_W-1:0] len_q;
    logic [3:0]       drain_cnt;
    logic             lfsr_load, lfsr_step, lfsr_bit;
    logic             out_nxt;
    logic             last_bit;

    function automatic logic [15:0] crc_step(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? CRC_POLY : 16'h0000);
    endfunction

    function automatic logic pat_bit(input mode_t m, input logic [CNT_W-1:0] k,
                                     input logic lb);
        case (m)
            MODE_LFSR:  return lb;
            MODE_PULSE: return (k == '0);
            default:    return ~k[0];
        endcase
    endfunction

    path_stim_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .step    (lfsr_step),
        .nxt_bit (lfsr_bit)
    );

    assign last_bit = (bit_cnt == len_q - 1'b1);

    // Outputs are registered, so the next bit is computed from next-cycle values.
    always_comb begin
        state_nxt = state;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        out_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    if (burst_len != '0) begin
                        state_nxt = ST_RUN;
                        out_nxt   = pat_bit(mode_t'(mode), '0, SEED[0]);
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_RUN: begin
                if (last_bit || stop) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    lfsr_step = (mode_q == MODE_LFSR);
                    out_nxt   = pat_bit(mode_q, bit_cnt + 1'b1, lfsr_bit);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 4'(DRAIN_CYC - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out       <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_cnt   <= '0;
            sig       <= CRC_INIT;
            mode_q    <= MODE_TOGGLE;
            len_q     <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            out       <= out_nxt;
            valid     <= (state_nxt == ST_RUN);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_DONE);
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 4'd1 : 4'd0;
            if (state == ST_IDLE && start) begin
                mode_q  <= mode_t'(mode);
                len_q   <= burst_len;
                bit_cnt <= '0;
                sig     <= CRC_INIT;
            end
            if (state == ST_RUN) begin
                bit_cnt <= bit_cnt + 1'b1;
                sig     <= crc_step(sig, out);
            end
        end
    end

endmodule

// File: tb/tb_path_stim_gen.sv
// Scenario bench for path_stim_gen with a bit-level scoreboard on the serial output.
module tb_path_stim_gen;

    localparam int          CNT_W     = 16;
    localparam int          DRAIN_CYC = 2;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [CNT_W-1:0] burst_len = '0;
    logic             out, valid, busy, done;
    logic [CNT_W-1:0] bit_cnt;
    logic [15:0]      sig;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          exp_q[$];
    logic [15:0] exp_sig;

    always #5 clk = ~clk;

    path_stim_gen #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC), .SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .burst_len (burst_len),
        .out       (out),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .bit_cnt   (bit_cnt),
        .sig       (sig)
    );

    // Scoreboard: every valid bit is checked against the next expected bit.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: valid bit out=%0b, expected no bit", out);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (out !== e) begin
                    n_err++;
                    $display("FAIL sb_bit: out=%0b expected %0b", out, e);
                end
            end
        end
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] s, input bit b);
        logic fb;
        fb = s[15] ^ b;
        s  = s << 1;
        if (fb) s = s ^ 16'h1021;
        return s;
    endfunction

    task automatic push_model(input logic [1:0] m, input int nbits);
        logic [15:0] l = SEED;
        logic [15:0] s = 16'hFFFF;
        bit          b;
        for (int k = 0; k < nbits; k++) begin
            case (m)
                2'd1:    b = l[0];
                2'd2:    b = (k == 0);
                default: b = (k % 2 == 0);
            endcase
            exp_q.push_back(b);
            s = crc_upd(s, b);
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        exp_sig = s;
    endtask

    // Called at a negedge; returns just after the accepting edge N.
    task automatic start_burst(input logic [1:0] m, input int len, input int nbits);
        push_model(m, nbits);
        mode      = m;
        burst_len = CNT_W'(len);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out !== 1'b0)    begin n_err++; $display("FAIL rst_out: got %b want 0", out); end
        n_cmp++; if (valid !== 1'b0)  begin n_err++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (bit_cnt !== '0)  begin n_err++; $display("FAIL rst_bit_cnt: got %0d want 0", bit_cnt); end
        n_cmp++; if (sig !== 16'hFFFF) begin n_err++; $display("FAIL rst_sig: got %h want ffff", sig); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_toggle;
        logic ev, ed, eb;
        start_burst(2'd0, 4, 4);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            ev = (c <= 4); ed = (c == 7); eb = (c <= 7);
            n_cmp++; if (valid !== ev) begin n_err++; $display("FAIL toggle_valid c=%0d: got %b want %b", c, valid, ev); end
            n_cmp++; if (done !== ed)  begin n_err++; $display("FAIL toggle_done c=%0d: got %b want %b", c, done, ed); end
            n_cmp++; if (busy !== eb)  begin n_err++; $display("FAIL toggle_busy c=%0d: got %b want %b", c, busy, eb); end
            if (!ev) begin
                n_cmp++; if (out !== 1'b0) begin n_err++; $display("FAIL toggle_idle_out c=%0d: got %b want 0", c, out); end
            end
        end
        n_cmp++; if (bit_cnt !== 16'd4) begin n_err++; $display("FAIL toggle_bit_cnt: got %0d want 4", bit_cnt); end
        n_cmp++; if (sig !== exp_sig)   begin n_err++; $display("FAIL toggle_sig: got %h want %h", sig, exp_sig); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL toggle_left: got %0d bits pending want 0", exp_q.size()); end
    endtask

    task automatic test_lfsr;
        start_burst(2'd1, 4, 4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_cmp++; if (done !== (c == 7)) begin n_err++; $display("FAIL lfsr_done c=%0d: got %b want %b", c, done, (c == 7)); end
        end
        n_cmp++; if (dut.u_lfsr.lfsr !== 16'h559C) begin n_err++; $display("FAIL lfsr_state: got %h want 559c", dut.u_lfsr.lfsr); end
        n_cmp++; if (sig !== exp_sig)   begin n_err++; $display("FAIL lfsr_sig: got %h want %h", sig, exp_sig); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL lfsr_left: got %0d bits pending want 0", exp_q.size()); end
    endtask

    task automatic test_pulse;
        start_burst(2'd2, 3, 3);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_cmp++; if (valid !== (c <= 3)) begin n_err++; $display("FAIL pulse_valid c=%0d: got %b want %b", c, valid, (c <= 3)); end
        end
        n_cmp++; if (bit_cnt !== 16'd3) begin n_err++; $display("FAIL pulse_bit_cnt: got %0d want 3", bit_cnt); end
        n_cmp++; if (sig !== exp_sig)   begin n_err++; $display("FAIL pulse_sig: got %h want %h", sig, exp_sig); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pulse_left: got %0d bits pending want 0", exp_q.size()); end
    endtask

    task automatic test_zero_len;
        start_burst(2'd0, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_cmp++; if (valid !== 1'b0)    begin n_err++; $display("FAIL zero_valid c=%0d: got %b want 0", c, valid); end
            n_cmp++; if (done !== (c == 3)) begin n_err++; $display("FAIL zero_done c=%0d: got %b want %b", c, done, (c == 3)); end
            n_cmp++; if (busy !== (c <= 3)) begin n_err++; $display("FAIL zero_busy c=%0d: got %b want %b", c, busy, (c <= 3)); end
        end
        n_cmp++; if (sig !== 16'hFFFF) begin n_err++; $display("FAIL zero_sig: got %h want ffff", sig); end
        n_cmp++; if (bit_cnt !== '0)   begin n_err++; $display("FAIL zero_bit_cnt: got %0d want 0", bit_cnt); end
    endtask

    task automatic test_stop;
        start_burst(2'd0, 10, 3);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n_cmp++; if (valid !== (c <= 3)) begin n_err++; $display("FAIL stop_valid c=%0d: got %b want %b", c, valid, (c <= 3)); end
            n_cmp++; if (done !== (c == 6))  begin n_err++; $display("FAIL stop_done c=%0d: got %b want %b", c, done, (c == 6)); end
            n_cmp++; if (busy !== (c <= 6))  begin n_err++; $display("FAIL stop_busy c=%0d: got %b want %b", c, busy, (c <= 6)); end
            if (c == 2) begin start = 1'b1; mode = 2'd1; burst_len = 16'd5; end
            if (c == 3) begin start = 1'b0; stop = 1'b1; end
            if (c == 4) stop = 1'b0;
        end
        n_cmp++; if (bit_cnt !== 16'd3) begin n_err++; $display("FAIL stop_bit_cnt: got %0d want 3", bit_cnt); end
        n_cmp++; if (sig !== exp_sig)   begin n_err++; $display("FAIL stop_sig: got %h want %h", sig, exp_sig); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stop_left: got %0d bits pending want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        logic ev, ed, eb;
        push_model(2'd0, 2);
        push_model(2'd0, 2);
        mode = 2'd0; burst_len = 16'd2; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            ev = (c == 1 || c == 2 || c == 7 || c == 8);
            ed = (c == 5 || c == 11);
            eb = (c != 6 && c <= 11);
            n_cmp++; if (valid !== ev) begin n_err++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, valid, ev); end
            n_cmp++; if (done !== ed)  begin n_err++; $display("FAIL b2b_done c=%0d: got %b want %b", c, done, ed); end
            n_cmp++; if (busy !== eb)  begin n_err++; $display("FAIL b2b_busy c=%0d: got %b want %b", c, busy, eb); end
            if (c == 7) start = 1'b0;
        end
        n_cmp++; if (bit_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_bit_cnt: got %0d want 2", bit_cnt); end
        n_cmp++; if (sig !== exp_sig)   begin n_err++; $display("FAIL b2b_sig: got %h want %h", sig, exp_sig); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_left: got %0d bits pending want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_run;
        start_burst(2'd0, 10, 10);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out !== 1'b0)   begin n_err++; $display("FAIL mid_rst_out: got %b want 0", out); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL mid_rst_done: got %b want 0", done); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_no_done c=%0d: got %b want 0", c, done); end
        end
        start_burst(2'd0, 2, 2);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_cmp++; if (valid !== (c <= 2)) begin n_err++; $display("FAIL mid_new_valid c=%0d: got %b want %b", c, valid, (c <= 2)); end
            n_cmp++; if (done !== (c == 5))  begin n_err++; $display("FAIL mid_new_done c=%0d: got %b want %b", c, done, (c == 5)); end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_left: got %0d bits pending want 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_toggle();
        test_lfsr();
        test_pulse();
        test_zero_len();
        test_stop();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/path_stim_gen.md
# path_stim_gen

Launch-side stimulus generator for register-to-register path test structures. Drives a serial bit stream into the launch flop's D input of a delay-chain test cell, so capture flops at each chain tap see a defined, repeatable pattern. Runs one programmable burst per start request, then idles the line and reports a CRC signature of the emitted bits for comparison against the capture side.

## Interface
- `CNT_W`, 16: width of the burst length and bit counter.
- `DRAIN_CYC`, 2: idle cycles after the last bit before `done`. Legal range 1..15.
- `SEED`, 16'hACE1: LFSR load value at every start. Must be nonzero.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a burst. Sampled only in IDLE.
- `stop` in 1: abort the burst. Honoured only in RUN.
- `mode` in 2: pattern select, captured at start. 0 = TOGGLE, 1 = LFSR, 2 = PULSE, 3 = reserved (behaves as TOGGLE).
- `burst_len` in CNT_W: number of bits to emit, captured at start.
- `out` out 1: serial stimulus; connects to the test cell's `in`.
- `valid` out 1: `out` carries a pattern bit this cycle.
- `busy` out 1: burst in progress (RUN, DRAIN or DONE).
- `done` out 1: single-cycle completion pulse.
- `bit_cnt` out CNT_W: number of bits emitted in the current or last burst.
- `sig` out 16: CRC-16-CCITT over the emitted bits.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start` when `burst_len != 0`.
  - IDLE → DRAIN on `start` when `burst_len == 0`.
  - RUN → DRAIN after the last bit, or on `stop`.
  - DRAIN → DONE after `DRAIN_CYC` cycles.
  - DONE → IDLE after one cycle.
- At the start edge:
  - `mode` and `burst_len` are latched.
  - The LFSR is loaded with `SEED`.
  - `sig` is set to 16'hFFFF.
  - `bit_cnt` is cleared to 0.
- RUN emits one bit per cycle with `valid=1`, and `bit_cnt` increments after each bit. The pattern for bit index k is:
  - TOGGLE: `out` = 1 when k is even, 0 when k is odd.
  - LFSR: Fibonacci LFSR, x^16+x^14+x^13+x^11+1. `out` = lfsr[0]; fb = l[0]^l[2]^l[3]^l[5]; next = {fb, l[15:1]}.
  - PULSE: `out` = 1 only when k = 0.
- `sig` update on each valid bit: shift left by 1, XOR with 16'h1021 when sig[15]^out is 1.
- `stop` in RUN:
  - The bit on that cycle is still emitted and counted.
  - The next cycle is DRAIN.
  - Only a `stop` asserted on the last bit's cycle changes nothing.
- `start` outside IDLE is ignored; it is not queued. `stop` outside RUN is ignored.
- `out` = 0 and `valid` = 0 in every state except RUN.
- `bit_cnt` and `sig` hold their values from DONE until the next accepted start.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `out`=0, `valid`=0, `busy`=0, `done`=0, `bit_cnt`=0, `sig`=16'hFFFF, LFSR=`SEED`.
- Latency: `start` sampled at edge N → first bit on `out` during cycle N+1.
- A burst of length L:
  - `valid` is high for cycles N+1..N+L.
  - DRAIN covers N+L+1..N+L+DRAIN_CYC.
  - `done` is high at N+L+DRAIN_CYC+1.
- Zero-length burst: DRAIN begins at N+1 and `done` is high at N+DRAIN_CYC+1, with no valid bits and `sig` = 16'hFFFF.
- `busy` is high from N+1 through the `done` cycle inclusive.
- Earliest back-to-back restart: a `start` held high through the `done` cycle is accepted at the first IDLE edge after it.
- Reset asserted mid-burst: outputs go to their reset values immediately. No `done` pulse is produced for the aborted burst.
- `bit_cnt` saturation is impossible, because `bit_cnt` ≤ `burst_len` ≤ 2^CNT_W−1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `path_stim_pkg`: state enum, mode enum (including reserved), LFSR tap mask, CRC polynomial 16'h1021, CRC init 16'hFFFF.
- Sub-module `path_stim_lfsr`: 16-bit Fibonacci LFSR with `load` and `step` controls.
- Top level: FSM, counters, pattern mux, CRC.

## Test plan
- TOGGLE, burst_len=4, DRAIN_CYC=2:
  - `out` = 1,0,1,0 on N+1..N+4, with `valid` high over that span.
  - `done` high at N+7 only; `busy` high for N+1..N+7.
  - `bit_cnt`=4; `sig` matches the reference CRC model.
- LFSR, burst_len=4, SEED=16'hACE1: `out` = 1,0,0,0, and the LFSR state after the burst is 16'h559C.
- PULSE, burst_len=3: `out` = 1,0,0 and `bit_cnt`=3.
- burst_len=0: no `valid` cycles; `done` at N+3; `sig`=16'hFFFF; `bit_cnt`=0.
- TOGGLE, burst_len=10, `stop` asserted at the 3rd bit:
  - Exactly 3 bits emitted (1,0,1), `bit_cnt`=3.
  - `done` 2 cycles after DRAIN begins.
  - A `start` pulse during RUN is ignored.
- Reset asserted mid-RUN: `out`, `valid`, `busy` and `done` drop to 0 asynchronously, and no `done` is produced. After release, a new TOGGLE burst of 2 outputs 1,0.
